sfu_acc_act: RTL

- Parametrised special-function unit that sits downstream of the systolic-array output column.
- Accumulates signed partial sums into a per-output-channel register bank over a programmable number of passes.
- Then drains the bank through a selectable activation (bypass / ReLU / clamped ReLU) with a valid/ready output handshake.
- Replaces the fixed 16-channel, ReLU-only, free-running-pointer SFU with an explicit pass-controlled state machine, saturation and back-pressure.

---
 rtl/sfu_pkg.sv | 29 ++
 rtl/sfu_acc_act_act.sv | 36 +++
 rtl/sfu_acc_act.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sfu_pkg.sv
// Shared definitions for the special-function unit.
//   state_e      : FSM encoding (IDLE / ACCUM / DRAIN)
//   MODE_*       : activation select codes (3 is reserved and behaves as ReLU)
//   saturate()   : clips a signed 64-bit value to the signed range of width w
package sfu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_RELU   = 2'd1;
    localparam logic [1:0] MODE_CLAMP  = 2'd2;

    // Callers truncate the result to w bits; the value is guaranteed to fit.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/sfu_acc_act_act.sv
// Combinational saturate + activation stage.
//   acc_in    : signed accumulator value (ACC_BW)
//   mode      : 0 bypass, 1 ReLU, 2 clamped ReLU, 3 treated as ReLU
//   clamp_max : signed upper bound used in clamped ReLU mode
//   act_out   : signed activated result (PSUM_BW)
module sfu_act
    import sfu_pkg::*;
#(
    parameter int ACC_BW  = 20,
    parameter int PSUM_BW = 16
) (
    input  logic signed [ACC_BW-1:0]  acc_in,
    input  logic        [1:0]         mode,
    input  logic signed [PSUM_BW-1:0] clamp_max,
    output logic signed [PSUM_BW-1:0] act_out
);

    logic signed [PSUM_BW-1:0] x;

    assign x = PSUM_BW'(saturate(64'(acc_in), PSUM_BW));

    always_comb begin
        act_out = x;
        case (mode)
            MODE_BYPASS: act_out = x;
            MODE_CLAMP: begin
                // A negative bound leaves no legal non-negative value, so emit 0.
                if (clamp_max < 0 || x < 0) act_out = '0;
                else if (x > clamp_max)     act_out = clamp_max;
                else                        act_out = x;
            end
            default: act_out = (x < 0) ? '0 : x;
        endcase
    end

endmodule

// File: rtl/sfu_acc_act.sv
// Accumulate-then-activate special-function unit.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : job start pulse (IDLE only, ignored while done is high)
//   mode, clamp_max,
//   num_pass              : job configuration, latched at start (num_pass 0 == 1)
//   psum_in/in_valid/
//   in_ready              : partial-sum input; a beat transfers when in_valid && in_ready
//   out_data/out_ch/
//   out_valid/out_ready   : drained results; a channel transfers when out_valid && out_ready
//   busy, done            : job status; done pulses one cycle after the last channel
//   dbg_state             : current FSM state for observation
// Valid/ready: a transfer happens on a rising edge where both are high; the
// producer holds its data stable while valid is high and ready is low.
module sfu_acc_act
    import sfu_pkg::*;
#(
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 20,
    parameter int NUM_CH  = 16,
    parameter int PASS_W  = 4,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic        [1:0]         mode,
    input  logic signed [PSUM_BW-1:0] clamp_max,
    input  logic        [PASS_W-1:0]  num_pass,
    input  logic signed [PSUM_BW-1:0] psum_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [PSUM_BW-1:0] out_data,
    output logic        [CH_W-1:0]    out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic        [1:0]         dbg_state
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e                    state_q, state_d;
    logic        [CH_W-1:0]    in_ptr_q, in_ptr_d;
    logic        [CH_W-1:0]    out_ptr_q, out_ptr_d;
    logic        [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic        [1:0]         mode_q, mode_d;
    logic signed [PSUM_BW-1:0] clamp_q, clamp_d;
    logic        [PASS_W-1:0]  npass_q, npass_d;
    logic signed [ACC_BW-1:0]  bank_q [NUM_CH];
    logic signed [ACC_BW-1:0]  bank_d [NUM_CH];
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [PSUM_BW-1:0] out_data_q, out_data_d;
    logic        [CH_W-1:0]    out_ch_q, out_ch_d;
    logic                      done_q, done_d;

    logic        [PASS_W-1:0]  last_pass;
    logic signed [ACC_BW-1:0]  acc_cur;
    logic signed [63:0]        sum64;
    logic signed [ACC_BW-1:0]  acc_next;
    logic        [CH_W-1:0]    rd_idx;
    logic signed [PSUM_BW-1:0] act_out;

    assign last_pass = (npass_q == '0) ? '0 : npass_q - 1'b1;

    // Accumulate path: widen, add, then clip back so the bank never wraps.
    assign acc_cur  = bank_q[in_ptr_q];
    assign sum64    = 64'(acc_cur) + 64'(psum_in);
    assign acc_next = ACC_BW'(saturate(sum64, ACC_BW));

    // Drain read index: the channel that will be presented next cycle.
    // Outside DRAIN this is channel 0, loaded on entry to DRAIN.
    always_comb begin
        rd_idx = '0;
        if (state_q == ST_DRAIN && out_ptr_q != LAST_CH)
            rd_idx = out_ptr_q + 1'b1;
    end

    sfu_act #(
        .ACC_BW  (ACC_BW),
        .PSUM_BW (PSUM_BW)
    ) u_act (
        .acc_in    (bank_q[rd_idx]),
        .mode      (mode_q),
        .clamp_max (clamp_q),
        .act_out   (act_out)
    );

    always_comb begin
        state_d     = state_q;
        in_ptr_d    = in_ptr_q;
        out_ptr_d   = out_ptr_q;
        pass_cnt_d  = pass_cnt_q;
        mode_d      = mode_q;
        clamp_d     = clamp_q;
        npass_d     = npass_q;
        bank_d      = bank_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // done_q high means this is the pulse cycle; a start here is dropped.
                if (start && !done_q) begin
                    mode_d     = mode;
                    clamp_d    = clamp_max;
                    npass_d    = num_pass;
                    for (int i = 0; i < NUM_CH; i++) bank_d[i] = '0;
                    in_ptr_d   = '0;
                    out_ptr_d  = '0;
                    pass_cnt_d = '0;
                    in_ready_d = 1'b1;
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid && in_ready_q) begin
                    bank_d[in_ptr_q] = acc_next;
                    if (in_ptr_q == LAST_CH) begin
                        in_ptr_d = '0;
                        if (pass_cnt_q == last_pass) begin
                            // Channel 0 is already final, so present it right away.
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                            out_ptr_d   = '0;
                            out_ch_d    = '0;
                            out_data_d  = act_out;
                            state_d     = ST_DRAIN;
                        end else begin
                            pass_cnt_d = pass_cnt_q + 1'b1;
                        end
                    end else begin
                        in_ptr_d = in_ptr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (out_ptr_q == LAST_CH) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        out_ptr_d  = rd_idx;
                        out_ch_d   = rd_idx;
                        out_data_d = act_out;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            in_ptr_q    <= '0;
            out_ptr_q   <= '0;
            pass_cnt_q  <= '0;
            mode_q      <= '0;
            clamp_q     <= '0;
            npass_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ptr_q    <= in_ptr_d;
            out_ptr_q   <= out_ptr_d;
            pass_cnt_q  <= pass_cnt_d;
            mode_q      <= mode_d;
            clamp_q     <= clamp_d;
            npass_q     <= npass_d;
            for (int i = 0; i < NUM_CH; i++) bank_q[i] <= bank_d[i];
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
